// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display scanner: segment decode table and
// the all-off codes for the active-low anode and segment drives.
package hex_display_pkg;

    typedef logic [1:0] digit_t;

    localparam digit_t     LAST_DIGIT = 2'd3;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; element 0 is the rightmost entry.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 4-digit seven-segment driver. The display word is
// snapshotted once per frame so digits never tear on mid-frame writes.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_CYCLES    = 1000,
    parameter bit BLANK_LEADING   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] hex,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    localparam int CNT_W = (TICKS_PER_DIGIT > 2) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W:0]   BLANK_END = (CNT_W + 1)'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt;
    digit_t           digit;
    logic [15:0]      snap;
    logic             load_pend;

    logic             lead_zero;
    logic             slot_blank;
    logic [3:0]       nibble;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;

    // Upper digits whose nibble and everything above it are zero go dark.
    always_comb begin
        lead_zero = 1'b0;
        if (BLANK_LEADING) begin
            case (digit)
                2'd1:    lead_zero = (snap[15:4]  == 12'h000);
                2'd2:    lead_zero = (snap[15:8]  == 8'h00);
                2'd3:    lead_zero = (snap[15:12] == 4'h0);
                default: lead_zero = 1'b0;
            endcase
        end
    end

    always_comb begin
        nibble     = snap[{digit, 2'b00} +: 4];
        slot_blank = ({1'b0, cnt} < BLANK_END) || lead_zero;
        an_nxt     = AN_OFF;
        seg_nxt    = SEG_OFF;
        if (!slot_blank) begin
            an_nxt  = ~(4'b0001 << digit);
            seg_nxt = seg_decode(nibble);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            digit      <= '0;
            snap       <= '0;
            load_pend  <= 1'b1;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            if (load_pend) begin
                snap      <= hex;
                load_pend <= 1'b0;
            end
            if (cnt == CNT_MAX) begin
                cnt   <= '0;
                digit <= digit + 2'd1;
                // Arm the next snapshot so it lands on the frame's first cycle.
                if (digit == LAST_DIGIT)
                    load_pend <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            frame_tick <= load_pend;
            an         <= an_nxt;
            seg        <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed table-driven bench for hex_display_scanner across three parameter sets.
module tb_hex_display_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic [15:0] hex_a = '0, hex_b = '0, hex_c = '0;
    logic [3:0]  an_a, an_b, an_c;
    logic [6:0]  seg_a, seg_b, seg_c;
    logic        ft_a, ft_b, ft_c;

    hex_display_scanner #(.TICKS_PER_DIGIT(4), .BLANK_CYCLES(1), .BLANK_LEADING(1'b0)) dut_a (
        .clk(clk), .reset(rst_a), .hex(hex_a), .an(an_a), .seg(seg_a), .frame_tick(ft_a));
    hex_display_scanner #(.TICKS_PER_DIGIT(4), .BLANK_CYCLES(1), .BLANK_LEADING(1'b1)) dut_b (
        .clk(clk), .reset(rst_b), .hex(hex_b), .an(an_b), .seg(seg_b), .frame_tick(ft_b));
    hex_display_scanner #(.TICKS_PER_DIGIT(2), .BLANK_CYCLES(0), .BLANK_LEADING(1'b0)) dut_c (
        .clk(clk), .reset(rst_c), .hex(hex_c), .an(an_c), .seg(seg_c), .frame_tick(ft_c));

    typedef struct {
        int          dut;
        logic        rst;
        logic [15:0] hex;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        ft;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input int d, input logic r, input logic [15:0] h,
                        input logic [3:0] a, input logic [6:0] s, input logic f, input int n);
        vec_t v;
        v.dut = d; v.rst = r; v.hex = h; v.an = a; v.seg = s; v.ft = f;
        repeat (n) vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        // DUT A: 1234 with a mid-slot change to ABCD, then reset during digit 2.
        push(0, 1, 16'h1234, 4'hF, 7'h7F, 0, 2);
        push(0, 0, 16'h1234, 4'hF, 7'h7F, 1, 1);
        push(0, 0, 16'h1234, 4'hE, 7'h19, 0, 3);
        push(0, 0, 16'h1234, 4'hF, 7'h7F, 0, 1);
        push(0, 0, 16'hABCD, 4'hD, 7'h30, 0, 3);
        push(0, 0, 16'hABCD, 4'hF, 7'h7F, 0, 1);
        push(0, 0, 16'hABCD, 4'hB, 7'h24, 0, 3);
        push(0, 0, 16'hABCD, 4'hF, 7'h7F, 0, 1);
        push(0, 0, 16'hABCD, 4'h7, 7'h79, 0, 3);
        push(0, 0, 16'hABCD, 4'hF, 7'h7F, 1, 1);
        push(0, 0, 16'hABCD, 4'hE, 7'h21, 0, 3);
        push(0, 0, 16'hABCD, 4'hF, 7'h7F, 0, 1);
        push(0, 0, 16'hABCD, 4'hD, 7'h46, 0, 3);
        push(0, 0, 16'hABCD, 4'hF, 7'h7F, 0, 1);
        push(0, 0, 16'hABCD, 4'hB, 7'h03, 0, 3);
        push(0, 0, 16'hABCD, 4'hF, 7'h7F, 0, 1);
        push(0, 0, 16'hABCD, 4'h7, 7'h08, 0, 3);
        push(0, 0, 16'hABCD, 4'hF, 7'h7F, 1, 1);
        push(0, 0, 16'hABCD, 4'hE, 7'h21, 0, 3);
        push(0, 0, 16'hABCD, 4'hF, 7'h7F, 0, 1);
        push(0, 0, 16'hABCD, 4'hD, 7'h46, 0, 3);
        push(0, 0, 16'hABCD, 4'hF, 7'h7F, 0, 1);
        push(0, 0, 16'hABCD, 4'hB, 7'h03, 0, 1);
        push(0, 1, 16'h5678, 4'hF, 7'h7F, 0, 1);
        push(0, 0, 16'h5678, 4'hF, 7'h7F, 1, 1);
        push(0, 0, 16'h5678, 4'hE, 7'h00, 0, 3);
        push(0, 0, 16'h5678, 4'hF, 7'h7F, 0, 1);
        push(0, 0, 16'h5678, 4'hD, 7'h78, 0, 3);
        // DUT B: leading-zero blanking, 0070 then 0000.
        push(1, 1, 16'h0070, 4'hF, 7'h7F, 0, 2);
        push(1, 0, 16'h0070, 4'hF, 7'h7F, 1, 1);
        push(1, 0, 16'h0070, 4'hE, 7'h40, 0, 3);
        push(1, 0, 16'h0070, 4'hF, 7'h7F, 0, 1);
        push(1, 0, 16'h0070, 4'hD, 7'h78, 0, 3);
        push(1, 0, 16'h0070, 4'hF, 7'h7F, 0, 8);
        push(1, 0, 16'h0000, 4'hF, 7'h7F, 1, 1);
        push(1, 0, 16'h0000, 4'hE, 7'h40, 0, 3);
        push(1, 0, 16'h0000, 4'hF, 7'h7F, 0, 12);
        push(1, 0, 16'h0000, 4'hF, 7'h7F, 1, 1);
        // DUT C: no blanking, 2-cycle slots, sweep all 16 codes.
        push(2, 1, 16'h3210, 4'hF, 7'h7F, 0, 2);
        push(2, 0, 16'h3210, 4'hE, 7'h40, 1, 1);
        push(2, 0, 16'h3210, 4'hE, 7'h40, 0, 1);
        push(2, 0, 16'h3210, 4'hD, 7'h79, 0, 2);
        push(2, 0, 16'h3210, 4'hB, 7'h24, 0, 2);
        push(2, 0, 16'h3210, 4'h7, 7'h30, 0, 2);
        push(2, 0, 16'h7654, 4'hE, 7'h40, 1, 1);
        push(2, 0, 16'h7654, 4'hE, 7'h19, 0, 1);
        push(2, 0, 16'h7654, 4'hD, 7'h12, 0, 2);
        push(2, 0, 16'h7654, 4'hB, 7'h02, 0, 2);
        push(2, 0, 16'h7654, 4'h7, 7'h78, 0, 2);
        push(2, 0, 16'hBA98, 4'hE, 7'h19, 1, 1);
        push(2, 0, 16'hBA98, 4'hE, 7'h00, 0, 1);
        push(2, 0, 16'hBA98, 4'hD, 7'h10, 0, 2);
        push(2, 0, 16'hBA98, 4'hB, 7'h08, 0, 2);
        push(2, 0, 16'hBA98, 4'h7, 7'h03, 0, 2);
        push(2, 0, 16'hFEDC, 4'hE, 7'h00, 1, 1);
        push(2, 0, 16'hFEDC, 4'hE, 7'h46, 0, 1);
        push(2, 0, 16'hFEDC, 4'hD, 7'h21, 0, 2);
        push(2, 0, 16'hFEDC, 4'hB, 7'h06, 0, 2);
        push(2, 0, 16'hFEDC, 4'h7, 7'h0E, 0, 2);
        push(2, 0, 16'hFEDC, 4'hE, 7'h46, 1, 1);

        foreach (vq[i]) begin
            logic [3:0] a;
            logic [6:0] s;
            logic       f;
            case (vq[i].dut)
                0:       begin rst_a = vq[i].rst; hex_a = vq[i].hex; end
                1:       begin rst_b = vq[i].rst; hex_b = vq[i].hex; end
                default: begin rst_c = vq[i].rst; hex_c = vq[i].hex; end
            endcase
            @(posedge clk);
            #1;
            case (vq[i].dut)
                0:       begin a = an_a; s = seg_a; f = ft_a; end
                1:       begin a = an_b; s = seg_b; f = ft_b; end
                default: begin a = an_c; s = seg_c; f = ft_c; end
            endcase
            check("an", i, {12'h0, a}, {12'h0, vq[i].an});
            check("seg", i, {9'h0, s}, {9'h0, vq[i].seg});
            check("frame_tick", i, {15'h0, f}, {15'h0, vq[i].ft});
        end

        // Free-running DUT C: frame_tick every 8 cycles, never back to back.
        begin
            int   pulses = 0;
            int   doubles = 0;
            logic prev = ft_c;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (ft_c) pulses++;
                if (ft_c && prev) doubles++;
                prev = ft_c;
            end
            check("ft_pulse_count", 0, 16'(pulses), 16'd5);
            check("ft_back_to_back", 0, 16'(doubles), 16'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
